// File: rtl/seq_addsub_if.sv
`default_nettype none
// ============================================================================
// seq_addsub_if : request/result bundle for the sequential add/sub unit
// Rev 1.0
// ============================================================================
interface seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic             cin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             CF;
  logic             ZF;
  logic             SF;
  logic             OF;
  logic             AF;

  modport master (
    output start, op, cin, A, B,
    input  R, busy, done, CF, ZF, SF, OF, AF
  );

  modport slave (
    input  start, op, cin, A, B,
    output R, busy, done, CF, ZF, SF, OF, AF
  );
endinterface
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// seq_addsub : multi-cycle CHUNK-bits-per-cycle add/sub with 8088-style flags
// Rev 1.0
// ============================================================================
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  wire         clk,
  input  wire         rst_n,
  seq_addsub_if.slave bus
);
  localparam int N     = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = $clog2(WIDTH);

  generate
    if (WIDTH < 8 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("seq_addsub: illegal WIDTH/CHUNK configuration");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;
  logic             af_q, af_d;

  logic [IDX_W-1:0] w_base;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_s_slice;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_new;
  logic             w_c_msb_in;
  logic             w_c4;

  // One slice of the ripple per cycle, LSB slice first.
  always_comb begin
    w_base    = IDX_W'(cnt_q) * IDX_W'(CHUNK);
    w_a_slice = a_q[w_base +: CHUNK];
    w_b_slice = b_q[w_base +: CHUNK];
    {w_cout, w_s_slice} = {1'b0, w_a_slice} + {1'b0, w_b_slice}
                        + {{CHUNK{1'b0}}, carry_q};
    w_sum_new = sum_q;
    w_sum_new[w_base +: CHUNK] = w_s_slice;
    w_last    = (cnt_q == CNT_W'(N - 1));
    // Carry into a bit is recovered from its operand bits and sum bit.
    w_c_msb_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ w_sum_new[WIDTH-1];
    w_c4       = a_q[4] ^ b_q[4] ^ w_sum_new[4];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    af_d    = af_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.A;
          b_d   = bus.op[1] ? ~bus.B : bus.B;
          sub_d = bus.op[1];
          case (bus.op)
            2'b00:   carry_d = 1'b0;
            2'b01:   carry_d = bus.cin;
            2'b10:   carry_d = 1'b1;
            default: carry_d = ~bus.cin;
          endcase
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = w_sum_new;
        carry_d = w_cout;
        cnt_d   = cnt_q + 1'b1;
        if (w_last) begin
          r_d     = w_sum_new;
          // Subtraction reports borrows, i.e. inverted carries.
          cf_d    = w_cout ^ sub_q;
          af_d    = w_c4 ^ sub_q;
          of_d    = w_c_msb_in ^ w_cout;
          sf_d    = w_sum_new[WIDTH-1];
          zf_d    = (w_sum_new == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
      af_q    <= af_d;
    end
  end

  assign bus.R    = r_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.CF   = cf_q;
  assign bus.ZF   = zf_q;
  assign bus.SF   = sf_q;
  assign bus.OF   = of_q;
  assign bus.AF   = af_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_seq_addsub : directed + random checks of seq_addsub against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_seq_addsub;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(WIDTH)) bus ();

  seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_r     = '0;
  logic [4:0]  exp_flags = '0;  // {CF,ZF,SF,OF,AF}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {bus.CF, bus.ZF, bus.SF, bus.OF, bus.AF};
  endfunction

  // Returns {CF,ZF,SF,OF,AF,R} from whole-word arithmetic.
  function automatic logic [20:0] model(input logic [1:0] op, input logic cin,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] be;
    logic        ci;
    int unsigned full;
    int unsigned low;
    int unsigned mid;
    logic        co;
    logic        c4;
    logic        c15;
    logic [15:0] r;
    be = op[1] ? ~b : b;
    case (op)
      2'd0:    ci = 1'b0;
      2'd1:    ci = cin;
      2'd2:    ci = 1'b1;
      default: ci = ~cin;
    endcase
    full = 32'(a) + 32'(be) + 32'(ci);
    low  = 32'(a[3:0]) + 32'(be[3:0]) + 32'(ci);
    mid  = 32'(a[14:0]) + 32'(be[14:0]) + 32'(ci);
    co   = (full >= 32'd65536);
    c4   = (low >= 32'd16);
    c15  = (mid >= 32'd32768);
    r    = 16'(full % 32'd65536);
    return {co ^ op[1], (r == 16'd0), r[15], c15 ^ co, c4 ^ op[1], r};
  endfunction

  // Call right after a falling edge; returns right after a falling edge.
  task automatic run_op(input logic [1:0] op, input logic cin, input logic [15:0] a,
                        input logic [15:0] b, input bit inject);
    logic [20:0] m;
    m = model(op, cin, a, b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.cin   = cin;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_at_start", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    bus.op    = 2'($urandom);
    bus.cin   = 1'($urandom);
    for (int i = 1; i <= N; i++) begin
      if (inject && i == 2) bus.start = 1'b1;
      @(posedge clk); #1;
      if (i < N) begin
        check("done_during_run", 32'(bus.done), 32'd0);
        check("r_hold_run", 32'(bus.R), 32'(exp_r));
        check("flags_hold_run", 32'(flags_now()), 32'(exp_flags));
      end else begin
        check("done_pulse", 32'(bus.done), 32'd1);
        check("result", 32'(bus.R), 32'(m[15:0]));
        check("flags", 32'(flags_now()), 32'(m[20:16]));
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    exp_r     = m[15:0];
    exp_flags = m[20:16];
    if (inject) bus.start = 1'b1;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);
    check("r_hold_idle", 32'(bus.R), 32'(exp_r));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    bit saw_done;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.cin   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #3;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_r", 32'(bus.R), 32'd0);
    check("rst_flags", 32'(flags_now()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(2'd2, 1'b0, 16'h8000, 16'h0001, 1'b0);
    run_op(2'd2, 1'b0, 16'h0000, 16'h0001, 1'b0);
    run_op(2'd3, 1'b1, 16'h0005, 16'h0003, 1'b0);
    run_op(2'd1, 1'b1, 16'h7FFF, 16'h0000, 1'b0);
    run_op(2'd0, 1'b0, 16'h1234, 16'h4321, 1'b1);

    // Reset in the third RUN cycle aborts the operation.
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.A     = 16'h0F0F;
    bus.B     = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_r", 32'(bus.R), 32'd0);
    check("abort_flags", 32'(flags_now()), 32'd0);
    exp_r     = '0;
    exp_flags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    @(negedge clk);
    run_op(2'd0, 1'b0, 16'h0001, 16'h0001, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = (t % 8 == 0) ? ra : 16'($urandom);
      run_op(2'($urandom_range(0, 3)), 1'($urandom), ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; it SHALL have no other clock or reset.
REQ-002 Parameter WIDTH SHALL default to 16 and set the operand/result width.
REQ-003 Parameter CHUNK SHALL default to 4 and set the bits processed per cycle.
REQ-004 Port clk SHALL be an input, 1 bit wide: the rising-edge clock.
REQ-005 Port rst_n SHALL be an input, 1 bit wide: the asynchronous active-low reset.
REQ-006 Port start SHALL be an input, 1 bit wide: the operation request.
REQ-007 Port op SHALL be an input, 2 bits wide: 00 ADD, 01 ADC, 10 SUB, 11 SBB.
REQ-008 Port cin SHALL be an input, 1 bit wide: the carry/borrow input, used by ADC and SBB only.
REQ-009 Port A SHALL be an input, WIDTH bits wide: operand A.
REQ-010 Port B SHALL be an input, WIDTH bits wide: operand B.
REQ-011 Port R SHALL be an output, WIDTH bits wide: the result.
REQ-012 Port busy SHALL be an output, 1 bit wide: the block is not idle.
REQ-013 Port done SHALL be an output, 1 bit wide: a one-cycle result-valid pulse.
REQ-014 Ports CF, ZF, SF, OF and AF SHALL be outputs, 1 bit wide each: the 8088-style flags.

Function
REQ-015 The configuration SHALL be legal only when WIDTH >= 8, CHUNK >= 1 and WIDTH % CHUNK == 0; an illegal configuration SHALL fail elaboration.
REQ-016 The block SHALL use N = WIDTH/CHUNK as its cycle count.
REQ-017 The state machine SHALL have three states: IDLE, RUN and DONE; busy = (state != IDLE) and done = (state == DONE).
REQ-018 In IDLE, a start sampled high at edge k SHALL latch A, the effective B and the effective carry-in, clear the chunk counter and move the state to RUN.
REQ-019 The effective operands SHALL be: ADD uses B with carry-in 0; ADC uses B with carry-in cin; SUB uses ~B with carry-in 1; SBB uses ~B with carry-in ~cin.
REQ-020 At each of edges k+1 through k+N in RUN, the block SHALL add one CHUNK-bit slice, from the LSB slice upward, and propagate the carry to the next slice.
REQ-021 At edge k+N, the last slice SHALL be written, the flags SHALL be updated and the state SHALL move to DONE.
REQ-022 At edge k+N+1, the state SHALL move from DONE to IDLE.
REQ-023 The latency SHALL be N cycles from the start edge to done high, and done SHALL be high for exactly one cycle.
REQ-024 R and the flags SHALL hold their values from DONE until the next accepted start, and SHALL not change during the next RUN until its final edge.
REQ-025 R SHALL equal (A + Beff + cineff) mod 2^WIDTH, with no wider intermediate result exposed.
REQ-026 CF SHALL be the carry out of the MSB for ADD/ADC, and its inverse (borrow) for SUB/SBB.
REQ-027 AF SHALL be the carry out of bit 3 for ADD/ADC, and its inverse for SUB/SBB.
REQ-028 OF SHALL be (carry into the MSB) XOR (carry out of the MSB).
REQ-029 SF SHALL equal R[WIDTH-1].
REQ-030 ZF SHALL be 1 exactly when R == 0.
REQ-031 When CHUNK == WIDTH (N = 1), the latency SHALL be one cycle and all of the above rules SHALL still hold.
REQ-032 A start while busy (RUN or DONE) SHALL be ignored: it SHALL not be queued and SHALL not corrupt latched operands.
REQ-033 Changes on A, B, op and cin after the start edge SHALL have no effect on the operation in progress.

Reset
REQ-034 When rst_n is low, regardless of the clock, the block SHALL force state = IDLE, busy = 0, done = 0, R = 0 and CF = ZF = SF = OF = AF = 0, and SHALL clear all internal registers.
REQ-035 A reset during RUN or DONE SHALL abort the operation, produce no done pulse and discard the partial result.
REQ-036 The first start SHALL be accepted at the first rising edge with rst_n high.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-037 ADD with A=FFFF, B=0001 -> R=0000, CF=1, ZF=1, AF=1, OF=0, SF=0; done high exactly 4 cycles after the start edge, for 1 cycle.
REQ-038 SUB with A=8000, B=0001 -> R=7FFF, OF=1, CF=0, SF=0, AF=1, ZF=0.
REQ-039 SUB with A=0000, B=0001 -> R=FFFF, CF=1, SF=1, AF=1, OF=0, ZF=0; SBB with A=0005, B=0003, cin=1 -> R=0001, CF=0.
REQ-040 ADC with A=7FFF, B=0000, cin=1 -> R=8000, OF=1, SF=1, AF=1, CF=0.
REQ-041 A start pulse 2 cycles into RUN with different operands -> ignored; the original result and a single done pulse are produced.
REQ-042 rst_n low in the 3rd RUN cycle -> busy=0, R=0 and all flags=0 immediately; no done pulse; a new ADD 0001+0001 afterwards -> R=0002.
